// File: rtl/mont_pkg.sv
// Shared Montgomery package: FSM state encoding and default operand width.
// Used by mont_enc and mont_mult.
package mont_pkg;

    localparam int MONT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mont_state_t;

endpackage

// File: rtl/mont_dbl_mod.sv
// Combinational modular doubling: dbl = (2*acc) mod N, for acc < N.
// The doubled value is carried in WIDTH+1 bits so that a modulus close to
// 2^WIDTH never loses the top bit before the compare/subtract.
module mont_dbl_mod #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] dbl
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] n_ext;
    logic [WIDTH:0] diff;

    // Double, then subtract N once if the doubled value reached the modulus.
    always_comb begin
        t     = {acc, 1'b0};
        n_ext = {1'b0, N};
        diff  = t - n_ext;
        dbl   = (t >= n_ext) ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    end

endmodule

// File: rtl/mont_enc.sv
// Montgomery-domain encoder: z_o = x_i * 2^WIDTH mod N, computed by WIDTH
// successive modular doublings (one per clock) starting from x_i.
// Optional feature: define MONT_ENC_CNT_EN to expose the iteration counter
// on cnt_o.
module mont_enc
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] z_o,
    output logic             done_o,
`ifdef MONT_ENC_CNT_EN
    output logic [7:0]       cnt_o,
`endif
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    mont_state_t      state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx, dbl;
    logic [CW-1:0]    cnt, cnt_nx;

    mont_dbl_mod #(.WIDTH(WIDTH)) u_dbl (
        .acc (acc),
        .N   (N),
        .dbl (dbl)
    );

    // State, accumulator and counter registers; reset clears all of them
    // without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic. acc is only written on an accepted start or a RUN
    // step, so it holds the last result through DONE and IDLE. cnt goes back
    // to 0 on leaving DONE so it reads zero whenever the FSM is idle.
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (start_i) begin
                    acc_nx   = x_i;
                    cnt_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                acc_nx = dbl;
                cnt_nx = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1))
                    state_nx = DONE;
            end
            DONE: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign z_o    = acc;
    assign done_o = (state == DONE);
    assign busy_o = (state != IDLE);
`ifdef MONT_ENC_CNT_EN
    assign cnt_o  = 8'(cnt);
`endif

endmodule

// File: tb/tb_mont_enc.sv
// Directed bench for mont_enc: one WIDTH=4 instance driven from a vector
// table plus hand-written multi-cycle sequences, and one WIDTH=64 instance.
module tb_mont_enc;

    logic clk = 1'b0;
    logic rst;

    logic        start4;
    logic [3:0]  n4, x4, z4;
    logic        done4, busy4;

    logic        start64;
    logic [63:0] n64, x64, z64;
    logic        done64, busy64;

`ifdef MONT_ENC_CNT_EN
    logic [7:0]  cnt4, cnt64;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mont_enc #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start4),
        .N       (n4),
        .x_i     (x4),
        .z_o     (z4),
        .done_o  (done4),
`ifdef MONT_ENC_CNT_EN
        .cnt_o   (cnt4),
`endif
        .busy_o  (busy4)
    );

    mont_enc #(.WIDTH(64)) dut64 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start64),
        .N       (n64),
        .x_i     (x64),
        .z_o     (z64),
        .done_o  (done64),
`ifdef MONT_ENC_CNT_EN
        .cnt_o   (cnt64),
`endif
        .busy_o  (busy64)
    );

    typedef struct {
        logic [3:0] n;
        logic [3:0] x;
        logic [3:0] z;
    } vec4_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge with dut4 idle. Returns the result and the
    // number of edges after the start edge at which done_o became visible
    // (0 if it never did within the budget).
    task automatic run4(input logic [3:0] n, input logic [3:0] x,
                        output logic [3:0] z, output int lat);
        n4 = n; x4 = x; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        z = 4'h0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done4) begin
                lat = k;
                z = z4;
                break;
            end
        end
    endtask

    task automatic run64(input logic [63:0] n, input logic [63:0] x,
                         output logic [63:0] z, output int lat);
        n64 = n; x64 = x; start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        lat = 0;
        z = 64'h0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done64) begin
                lat = k;
                z = z64;
                break;
            end
        end
    endtask

    initial begin
        vec4_t       tbl [9];
        logic [3:0]  z;
        logic [63:0] zz;
        int          lat;
        int          c1, c2;

        // n, x, expected x*16 mod n
        tbl[0] = '{4'd7,  4'd3,  4'd6};
        tbl[1] = '{4'd15, 4'd14, 4'd14};
        tbl[2] = '{4'd15, 4'd0,  4'd0};
        tbl[3] = '{4'd7,  4'd5,  4'd3};
        tbl[4] = '{4'd7,  4'd0,  4'd0};
        tbl[5] = '{4'd7,  4'd6,  4'd5};
        tbl[6] = '{4'd13, 4'd1,  4'd3};
        tbl[7] = '{4'd15, 4'd1,  4'd1};
        tbl[8] = '{4'd9,  4'd4,  4'd1};

        rst = 1'b1;
        start4 = 1'b0; n4 = 4'd7; x4 = 4'd0;
        start64 = 1'b0; n64 = 64'hFFFF_FFFF_FFFF_FFC5; x64 = 64'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset z4", z4, 0);
        chk("reset done4", done4, 0);
        chk("reset busy4", busy4, 0);
        chk("reset z64", z64, 0);
        chk("reset busy64", busy64, 0);
`ifdef MONT_ENC_CNT_EN
        chk("reset cnt4", cnt4, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven encodes: latency, result, one-cycle done pulse.
        foreach (tbl[i]) begin
            run4(tbl[i].n, tbl[i].x, z, lat);
            chk($sformatf("lat4[%0d]", i), lat, 4);
            chk($sformatf("z4[%0d]", i), z, tbl[i].z);
            @(posedge clk); #1;
            chk($sformatf("done4 off[%0d]", i), done4, 0);
            chk($sformatf("busy4 off[%0d]", i), busy4, 0);
            chk($sformatf("z4 hold[%0d]", i), z4, tbl[i].z);
        end

        // Starts during RUN and during the done cycle are ignored.
        n4 = 4'd7; x4 = 4'd3; start4 = 1'b1;
        @(posedge clk); #1;               // e0
        start4 = 1'b0;
        chk("busy4 run", busy4, 1);
        @(posedge clk); #1;               // e1
        x4 = 4'd5; start4 = 1'b1;
        @(posedge clk); #1;               // e2
        start4 = 1'b0;
`ifdef MONT_ENC_CNT_EN
        chk("cnt4 mid", cnt4, 2);
`endif
        @(posedge clk); #1;               // e3
        start4 = 1'b1;
        @(posedge clk); #1;               // e4
        chk("ign done4", done4, 1);
        chk("ign z4", z4, 6);
        @(posedge clk); #1;               // e5: back in IDLE, start in DONE dropped
        start4 = 1'b0;
        chk("ign busy4 e5", busy4, 0);
        chk("ign done4 e5", done4, 0);
        @(posedge clk); #1;
        chk("ign no queue", busy4, 0);
        chk("ign z4 hold", z4, 6);
`ifdef MONT_ENC_CNT_EN
        chk("cnt4 idle", cnt4, 0);
`endif
        run4(4'd7, 4'd5, z, lat);
        chk("after ign z4", z, 3);
        chk("after ign lat", lat, 4);
        @(posedge clk); #1;

        // Start held high: one result every WIDTH+2 cycles.
        n4 = 4'd7; x4 = 4'd3; start4 = 1'b1;
        c1 = 0; c2 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                if (c1 == 0) c1 = i;
                else begin
                    c2 = i;
                    break;
                end
            end
        end
        start4 = 1'b0;
        chk("b2b first", c1, 5);
        chk("b2b second", c2, 11);
        chk("b2b z4", z4, 6);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b idle", busy4, 0);

        // Reset in the middle of RUN takes effect without a clock.
        n4 = 4'd7; x4 = 4'd3; start4 = 1'b1;
        @(posedge clk); #1;               // e0
        start4 = 1'b0;
        repeat (2) @(posedge clk);        // e1, e2
        #1;
        chk("pre-rst busy4", busy4, 1);
        rst = 1'b1;
        #1;
        chk("rst z4", z4, 0);
        chk("rst busy4", busy4, 0);
        chk("rst done4", done4, 0);
`ifdef MONT_ENC_CNT_EN
        chk("rst cnt4", cnt4, 0);
`endif
        @(posedge clk); #1;
        chk("rst hold done4", done4, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst busy4", busy4, 0);
        run4(4'd7, 4'd3, z, lat);
        chk("restart z4", z, 6);
        chk("restart lat", lat, 4);
        @(posedge clk); #1;

        // Wide modulus: 2^64 mod (2^64-59) = 59, exercising the top carry.
        run64(64'hFFFF_FFFF_FFFF_FFC5, 64'd1, zz, lat);
        chk("lat64", lat, 64);
        chk("z64 x=1", zz, 64'h3B);
        @(posedge clk); #1;
        chk("done64 off", done64, 0);
        chk("busy64 off", busy64, 0);
        // (N-1)*2^64 mod N = N-59
        run64(64'hFFFF_FFFF_FFFF_FFC5, 64'hFFFF_FFFF_FFFF_FFC4, zz, lat);
        chk("lat64 b", lat, 64);
        chk("z64 x=N-1", zz, 64'hFFFF_FFFF_FFFF_FF8A);
        @(posedge clk); #1;
        chk("done64 off b", done64, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
